// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
// Shares the LED register-file port between two masters:
//   m0 = I2C controller (host access, fixed priority, burst lock)
//   m1 = on-chip pattern sequencer
// Accesses are serialised IDLE -> ACCESS -> RESP -> IDLE. All outputs are
// registered, so one access completes every three clocks back to back.
//
// Optional feature: define STARVE_GUARD_EN to add an m1 starvation guard.
// m1 is then forced through after MAX_WAIT lost arbitrations, unless m0 holds
// the lock. Without the macro, m0 priority is strict and the guard logic is
// not built.
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    // master 0: I2C controller
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic [DATA_BITS-1:0] m0_wdata,
    input  logic                 m0_lock,
    output logic                 m0_done,
    output logic [DATA_BITS-1:0] m0_rdata,
    // master 1: pattern sequencer
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_wdata,
    output logic                 m1_done,
    output logic [DATA_BITS-1:0] m1_rdata,
    // register-file port
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    output logic                 reg_w_en,
    output logic                 reg_r_en,
    input  logic [DATA_BITS-1:0] reg_rdata,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]           state_q,     state_d;
    logic                 owner_q,     owner_d;     // 0 = m0, 1 = m1
    logic [ADDR_BITS-1:0] reg_addr_q,  reg_addr_d;
    logic [DATA_BITS-1:0] reg_wdata_q, reg_wdata_d;
    logic                 reg_w_en_q,  reg_w_en_d;
    logic                 reg_r_en_q,  reg_r_en_d;
    logic                 m0_done_q,   m0_done_d;
    logic                 m1_done_q,   m1_done_d;
    logic [DATA_BITS-1:0] m0_rdata_q,  m0_rdata_d;
    logic [DATA_BITS-1:0] m1_rdata_q,  m1_rdata_d;
    logic                 busy_q,      busy_d;

    logic                 force_m1;
    logic                 grant_m0;
    logic                 grant_m1;

`ifdef STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    // m1 overrides m0 priority once it has waited MAX_WAIT arbitrations;
    // the burst lock still wins so I2C bursts stay atomic
    assign force_m1 = (starve_q == CNT_W'(MAX_WAIT)) && !m0_lock;

    // Count m1 priority losses in IDLE; lock-blocked cycles are not losses
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (grant_m1) begin
                starve_d = '0;
            end else if (grant_m0 && m1_req && !m0_lock &&
                         (starve_q != CNT_W'(MAX_WAIT))) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    // Starve counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_m1 = 1'b0;
`endif

    // Arbitration: lock blocks m1, m0 wins ties unless the guard forces m1
    always_comb begin
        grant_m1 = m1_req && !m0_lock && (!m0_req || force_m1);
        grant_m0 = m0_req && !grant_m1;
    end

    // Next-state and registered-output logic for the access FSM
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_w_en_d  = 1'b0;
        reg_r_en_d  = 1'b0;
        m0_done_d   = 1'b0;
        m1_done_d   = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_m0 || grant_m1) begin
                    state_d = ST_ACCESS;
                    owner_d = grant_m1;
                    if (grant_m1) begin
                        reg_addr_d  = m1_addr;
                        reg_wdata_d = m1_wdata;
                        reg_w_en_d  = m1_we;
                        reg_r_en_d  = !m1_we;
                    end else begin
                        reg_addr_d  = m0_addr;
                        reg_wdata_d = m0_wdata;
                        reg_w_en_d  = m0_we;
                        reg_r_en_d  = !m0_we;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                // read data is combinational from reg_addr during the strobe
                if (reg_r_en_q) begin
                    if (owner_q) begin
                        m1_rdata_d = reg_rdata;
                    end else begin
                        m0_rdata_d = reg_rdata;
                    end
                end
                m0_done_d = !owner_q;
                m1_done_d = owner_q;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_w_en_q  <= 1'b0;
            reg_r_en_q  <= 1'b0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value regardless of statement order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_w_en_q  <= reg_w_en_d;
            reg_r_en_q  <= reg_r_en_d;
            m0_done_q   <= m0_done_d;
            m1_done_q   <= m1_done_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_w_en  = reg_w_en_q;
    assign reg_r_en  = reg_r_en_q;
    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_arbiter
// Scoreboard bench: each access is pushed (in expected grant order) when it
// is requested; a negedge monitor pops an entry on every register strobe and
// checks the done pulse and read data on the following cycle. Build with
// STARVE_GUARD_EN defined to exercise the starvation guard.
// ---------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;

    typedef struct {
        bit          m;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 0, m1_we = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_done, m1_done, reg_w_en, reg_r_en, busy;
    logic [DW-1:0] m0_rdata, m1_rdata, reg_wdata, reg_rdata;
    logic [AW-1:0] reg_addr;

    int total = 0;
    int bad   = 0;

    txn_t          sb[$];
    logic [DW-1:0] model_mem [8];
    logic [DW-1:0] rf [8];
    bit            rf_loaded = 0;

    // monitor state
    int            cyc = 0;
    int            strobe_cnt = 0;
    int            last_strobe_cyc = 0;
    int            prev_strobe_cyc = 0;
    bit            pending = 0;
    txn_t          cur;
    logic [DW-1:0] exp_rdata [2];

    reg_bus_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_rdata(m1_rdata),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_w_en(reg_w_en),
        .reg_r_en(reg_r_en), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // register file model: preset contents (addr a holds 0x37+a), then writes
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h37 + 8'(i);
            rf_loaded <= 1'b1;
        end else if (reg_w_en) begin
            rf[reg_addr] <= reg_wdata;
        end
    end
    assign reg_rdata = reg_r_en ? rf[reg_addr] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // expected result is derived from the bench's own memory model
    task automatic push(input bit m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.m = m; t.we = we; t.addr = a; t.wdata = d;
        t.rdata = model_mem[a];
        if (we) model_mem[a] = d;
        sb.push_back(t);
    endtask

    task automatic wait_done(input bit m);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m ? m1_done : m0_done) begin
                seen = 1;
                break;
            end
        end
        check(m ? "m1_done_timeout" : "m0_done_timeout", 32'(seen), 1);
    endtask

    task automatic drive(input bit m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!m) begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1;
        end
        wait_done(m);
        // drop the request inside the done cycle
        if (!m) m0_req = 0; else m1_req = 0;
    endtask

    task automatic access(input bit m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        push(m, we, a, d);
        drive(m, we, a, d);
    endtask

    // Monitor: strobes pop the scoreboard, done/rdata checked one cycle later
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pending      = 0;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
        end else begin
            bit strobe;
            strobe = reg_w_en | reg_r_en;
            check("busy", 32'(busy), 32'(strobe || pending));
            check("m0_done", 32'(m0_done), 32'(pending && !cur.m));
            check("m1_done", 32'(m1_done), 32'(pending && cur.m));
            if (pending) begin
                check("strobe_in_resp", 32'(strobe), 0);
                if (!cur.we) exp_rdata[cur.m] = cur.rdata;
                pending = 0;
            end
            check("m0_rdata", 32'(m0_rdata), 32'(exp_rdata[0]));
            check("m1_rdata", 32'(m1_rdata), 32'(exp_rdata[1]));
            if (strobe) begin
                if (sb.size() == 0) begin
                    check("spurious_strobe", 32'(strobe), 0);
                end else begin
                    cur = sb.pop_front();
                    check("both_strobes", 32'(reg_w_en & reg_r_en), 0);
                    check("strobe_we", 32'(reg_w_en), 32'(cur.we));
                    check("strobe_addr", 32'(reg_addr), 32'(cur.addr));
                    if (cur.we) check("strobe_wdata", 32'(reg_wdata), 32'(cur.wdata));
                    prev_strobe_cyc = last_strobe_cyc;
                    last_strobe_cyc = cyc;
                    strobe_cnt++;
                    pending = 1;
                end
            end
        end
    end

    initial begin
        int n;
        int target;
        bit hit;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h37 + 8'(i);
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_w_en", 32'(reg_w_en), 0);
        check("rst_r_en", 32'(reg_r_en), 0);
        check("rst_dones", 32'({m0_done, m1_done}), 0);
        check("rst_rdata", 32'({m0_rdata, m1_rdata}), 0);
        check("rst_addr_wdata", 32'({reg_addr, reg_wdata}), 0);
        reset = 0;
        repeat (2) @(negedge clk);

        // 1: m0 write
        access(0, 1, 3'd3, 8'hA5);
        repeat (2) @(negedge clk);

        // 2: m1 read of preset value 0x3C
        access(1, 0, 3'd5, 8'h00);
        check("t2_m1_rdata", 32'(m1_rdata), 32'h3C);
        repeat (2) @(negedge clk);

        // 3: simultaneous writes, m0 first, m1 three cycles later
        push(0, 1, 3'd7, 8'h77);
        push(1, 1, 3'd6, 8'h66);
        fork
            drive(0, 1, 3'd7, 8'h77);
            drive(1, 1, 3'd6, 8'h66);
        join
        check("t3_strobe_gap", 32'(last_strobe_cyc - prev_strobe_cyc), 3);
        repeat (2) @(negedge clk);

        // 4: lock with no m0 request holds m1 off
        m0_lock = 1;
        m1_we = 1; m1_addr = 3'd4; m1_wdata = 8'h44; m1_req = 1;
        repeat (10) @(negedge clk);
        check("t4_busy_locked", 32'(busy), 0);
        push(1, 1, 3'd4, 8'h44);
        m0_lock = 0;
        n = 0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (m1_done) begin hit = 1; break; end
        end
        m1_req = 0;
        check("t4_release_latency", 32'(hit ? n : -1), 2);
        repeat (2) @(negedge clk);

        // read back through both masters, including write-then-read
        access(0, 0, 3'd3, 8'h00);
        access(1, 0, 3'd4, 8'h00);
        for (int i = 0; i < 8; i++) begin
            access(1'(i % 2), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)));
        end
        repeat (2) @(negedge clk);

        // 5: m0 back-to-back with m1 held
        m0_we = 1; m0_addr = 3'd1; m0_wdata = 8'h11; m0_req = 1;
        m1_we = 1; m1_addr = 3'd2; m1_wdata = 8'h22; m1_req = 1;
`ifdef STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) push(0, 1, 3'd1, 8'h11);
        push(1, 1, 3'd2, 8'h22);
        push(0, 1, 3'd1, 8'h11);
`else
        for (int i = 0; i < 6; i++) push(0, 1, 3'd1, 8'h11);
`endif
        target = strobe_cnt + 6;
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (strobe_cnt >= target) begin hit = 1; break; end
        end
        check("t5_six_grants", 32'(hit), 1);
        m0_req = 0;
        m1_req = 0;
        repeat (4) @(negedge clk);
        check("t5_sb_drained", 32'(sb.size()), 0);

        // 6: reset during an m0 read access
        push(0, 0, 3'd2, 8'h00);
        m0_we = 0; m0_addr = 3'd2; m0_req = 1;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (reg_r_en) begin hit = 1; break; end
        end
        check("t6_read_started", 32'(hit), 1);
        #1;
        reset = 1;
        m0_req = 0;
        #1;
        check("t6_r_en_drop", 32'(reg_r_en), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_m0_rdata", 32'(m0_rdata), 0);
        check("t6_m0_done", 32'(m0_done), 0);
        repeat (2) @(negedge clk);
        check("t6_no_done_in_reset", 32'(m0_done), 0);
        sb.delete();
        push(0, 1, 3'd6, 8'h5A);
        m0_we = 1; m0_addr = 3'd6; m0_wdata = 8'h5A; m0_req = 1;
        #2;
        reset = 0;
        @(negedge clk);
        #1;
        check("t6_first_arb_wen", 32'(reg_w_en), 1);
        check("t6_first_arb_addr", 32'(reg_addr), 6);
        wait_done(0);
        m0_req = 0;
        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
